// File: rtl/clock_time_ctrl.sv
// Time-of-day sequencer: BCD HH:MM:SS cascade on 1 Hz tick plus a button-driven set-mode FSM.
// Optional build macro CLOCK_12H_EN adds a pm output and 12-hour presentation of the hour digits.
module clock_time_ctrl #(
   parameter logic [3:0] INIT_HR_T  = 4'd0,
   parameter logic [3:0] INIT_HR_U  = 4'd0,
   parameter logic [3:0] INIT_MIN_T = 4'd0,
   parameter logic [3:0] INIT_MIN_U = 4'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] hr_t,
   output logic [3:0] hr_u,
   output logic [3:0] min_t,
   output logic [3:0] min_u,
   output logic [3:0] sec_t,
   output logic [3:0] sec_u,
   output logic [1:0] mode,
   output logic [1:0] blank,
   output logic       day_pulse
`ifdef CLOCK_12H_EN
   ,
   output logic       pm
`endif
);

   typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_t;

   state_t     state_q, n_state;
   logic       blink_q, n_blink;
   logic [3:0] h_t, h_u;
   logic [3:0] n_ht, n_hu, n_mt, n_mu, n_st, n_su;
   logic       n_day;
   logic [8:0] h_inc, m_inc;

   // {wrap, tens, units} for a 00..23 hour pair
   function automatic logic [8:0] inc_hr(input logic [3:0] t, input logic [3:0] u);
      if (t == 4'd2 && u == 4'd3) return {1'b1, 4'd0, 4'd0};
      else if (u == 4'd9)         return {1'b0, t + 4'd1, 4'd0};
      else                        return {1'b0, t, u + 4'd1};
   endfunction

   function automatic logic [8:0] inc_min(input logic [3:0] t, input logic [3:0] u);
      if (u != 4'd9)       return {1'b0, t, u + 4'd1};
      else if (t == 4'd5)  return {1'b1, 4'd0, 4'd0};
      else                 return {1'b0, t + 4'd1, 4'd0};
   endfunction

`ifdef CLOCK_12H_EN
   // {pm, tens, units}: 00 -> 12 AM, 13..23 -> 01..11 PM
   function automatic logic [8:0] to12(input logic [3:0] t, input logic [3:0] u);
      logic [4:0] hv, dv;
      hv = 5'(t) * 5'd10 + 5'(u);
      if (hv == 5'd0)       dv = 5'd12;
      else if (hv > 5'd12)  dv = hv - 5'd12;
      else                  dv = hv;
      if (dv >= 5'd10) return {hv >= 5'd12, 4'd1, 4'(dv - 5'd10)};
      else             return {hv >= 5'd12, 4'd0, 4'(dv)};
   endfunction
`endif

   assign h_inc = inc_hr(h_t, h_u);
   assign m_inc = inc_min(min_t, min_u);
   assign mode  = state_q;

   always_comb begin
      n_state = state_q;
      n_blink = blink_q;
      n_ht    = h_t;
      n_hu    = h_u;
      n_mt    = min_t;
      n_mu    = min_u;
      n_st    = sec_t;
      n_su    = sec_u;
      n_day   = 1'b0;
      case (state_q)
         RUN: begin
            if (btn_mode) begin
               n_state = SET_HR;
               n_st    = 4'd0;
               n_su    = 4'd0;
               n_blink = 1'b0;
            end else if (tick) begin
               n_su = (sec_u == 4'd9) ? 4'd0 : sec_u + 4'd1;
               if (sec_u == 4'd9) n_st = (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
               if (sec_u == 4'd9 && sec_t == 4'd5) begin
                  {n_mt, n_mu} = m_inc[7:0];
                  if (m_inc[8]) begin
                     {n_ht, n_hu} = h_inc[7:0];
                     n_day        = h_inc[8];
                  end
               end
            end
         end
         SET_HR: begin
            if (btn_mode) begin
               n_state = SET_MIN;
               n_blink = 1'b0;
            end else begin
               if (tick)    n_blink      = ~blink_q;
               if (btn_inc) {n_ht, n_hu} = h_inc[7:0];
            end
         end
         SET_MIN: begin
            if (btn_mode) begin
               n_state = RUN;
               n_blink = 1'b0;
            end else begin
               if (tick)    n_blink      = ~blink_q;
               if (btn_inc) {n_mt, n_mu} = m_inc[7:0];
            end
         end
         default: begin
            n_state = RUN;
            n_blink = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RUN;
         blink_q   <= 1'b0;
         blank     <= 2'b00;
         day_pulse <= 1'b0;
         h_t       <= INIT_HR_T;
         h_u       <= INIT_HR_U;
         min_t     <= INIT_MIN_T;
         min_u     <= INIT_MIN_U;
         sec_t     <= 4'd0;
         sec_u     <= 4'd0;
`ifdef CLOCK_12H_EN
         {pm, hr_t, hr_u} <= to12(INIT_HR_T, INIT_HR_U);
`endif
      end else begin
         state_q   <= n_state;
         blink_q   <= n_blink;
         blank     <= {(n_state == SET_HR) && n_blink, (n_state == SET_MIN) && n_blink};
         day_pulse <= n_day;
         h_t       <= n_ht;
         h_u       <= n_hu;
         min_t     <= n_mt;
         min_u     <= n_mu;
         sec_t     <= n_st;
         sec_u     <= n_su;
`ifdef CLOCK_12H_EN
         {pm, hr_t, hr_u} <= to12(n_ht, n_hu);
`endif
      end
   end

`ifndef CLOCK_12H_EN
   assign hr_t = h_t;
   assign hr_u = h_u;
`endif

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl (INIT 23:59); the 12-hour checks build when CLOCK_12H_EN is defined.
module tb_clock_time_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
   logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
   logic [1:0] mode, blank;
   logic       day_pulse;
`ifdef CLOCK_12H_EN
   logic       pm;
`endif
   int cmp = 0;
   int bad = 0;

   clock_time_ctrl #(.INIT_HR_T(4'd2), .INIT_HR_U(4'd3), .INIT_MIN_T(4'd5), .INIT_MIN_U(4'd9)) dut (
      .clk(clk), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .hr_t(hr_t), .hr_u(hr_u), .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
      .mode(mode), .blank(blank), .day_pulse(day_pulse)
`ifdef CLOCK_12H_EN
      , .pm(pm)
`endif
   );

   always #5 clk = ~clk;

   wire [23:0] now_t = {hr_t, hr_u, min_t, min_u, sec_t, sec_u};

   // Expected displayed time as packed BCD digits
   function automatic logic [23:0] tm(input int h, input int m, input int s);
      int dh;
      dh = h;
`ifdef CLOCK_12H_EN
      dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
`endif
      return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic step(input logic t, input logic m, input logic i);
      tick = t; btn_mode = m; btn_inc = i;
      @(posedge clk); #1;
      tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic incs(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1);
   endtask

   // Set hours/minutes by increment counts from the current values, then return to RUN
   task automatic set_time(input int hinc, input int minc);
      step(1'b0, 1'b1, 1'b0);
      incs(hinc);
      step(1'b0, 1'b1, 1'b0);
      incs(minc);
      step(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      cmp++; if (now_t !== tm(23, 59, 0)) begin bad++; $display("FAIL reset_time got %h want %h", now_t, tm(23, 59, 0)); end
      cmp++; if ({mode, blank, day_pulse} !== 5'b0) begin bad++; $display("FAIL reset_ctrl got %b want 00000", {mode, blank, day_pulse}); end
   endtask

   task automatic test_midnight;
      ticks(59);
      cmp++; if (now_t !== tm(23, 59, 59)) begin bad++; $display("FAIL pre_midnight got %h want %h", now_t, tm(23, 59, 59)); end
      cmp++; if (day_pulse !== 1'b0) begin bad++; $display("FAIL day_early got %b want 0", day_pulse); end
      ticks(1);
      cmp++; if (now_t !== tm(0, 0, 0)) begin bad++; $display("FAIL midnight got %h want %h", now_t, tm(0, 0, 0)); end
      cmp++; if (day_pulse !== 1'b1) begin bad++; $display("FAIL day_pulse got %b want 1", day_pulse); end
      step(1'b0, 1'b0, 1'b0);
      cmp++; if (day_pulse !== 1'b0) begin bad++; $display("FAIL day_width got %b want 0", day_pulse); end
   endtask

   task automatic test_carries;
      set_time(9, 59);
      ticks(59);
      cmp++; if (now_t !== tm(9, 59, 59)) begin bad++; $display("FAIL t095959 got %h want %h", now_t, tm(9, 59, 59)); end
      ticks(1);
      cmp++; if (now_t !== tm(10, 0, 0)) begin bad++; $display("FAIL t100000 got %h want %h", now_t, tm(10, 0, 0)); end
      set_time(9, 59);
      ticks(59);
      cmp++; if (now_t !== tm(19, 59, 59)) begin bad++; $display("FAIL t195959 got %h want %h", now_t, tm(19, 59, 59)); end
      ticks(1);
      cmp++; if (now_t !== tm(20, 0, 0)) begin bad++; $display("FAIL t200000 got %h want %h", now_t, tm(20, 0, 0)); end
      step(1'b0, 1'b0, 1'b1);
      cmp++; if (now_t !== tm(20, 0, 0)) begin bad++; $display("FAIL run_inc_ignored got %h want %h", now_t, tm(20, 0, 0)); end
   endtask

   task automatic test_set_sequence;
      set_time(18, 37);
      ticks(25);
      cmp++; if (now_t !== tm(14, 37, 25)) begin bad++; $display("FAIL t143725 got %h want %h", now_t, tm(14, 37, 25)); end
      step(1'b0, 1'b1, 1'b0);
      cmp++; if ({mode, now_t} !== {2'd1, tm(14, 37, 0)}) begin bad++; $display("FAIL enter_set got %h want %h", {mode, now_t}, {2'd1, tm(14, 37, 0)}); end
      incs(10);
      cmp++; if (now_t !== tm(0, 37, 0)) begin bad++; $display("FAIL hr_wrap got %h want %h", now_t, tm(0, 37, 0)); end
      cmp++; if (day_pulse !== 1'b0) begin bad++; $display("FAIL set_day got %b want 0", day_pulse); end
      step(1'b0, 1'b1, 1'b0);
      incs(23);
      cmp++; if ({mode, now_t} !== {2'd2, tm(0, 0, 0)}) begin bad++; $display("FAIL min_wrap got %h want %h", {mode, now_t}, {2'd2, tm(0, 0, 0)}); end
      step(1'b0, 1'b1, 1'b0);
      cmp++; if ({mode, now_t} !== {2'd0, tm(0, 0, 0)}) begin bad++; $display("FAIL back_run got %h want %h", {mode, now_t}, {2'd0, tm(0, 0, 0)}); end
      ticks(1);
      cmp++; if (now_t !== tm(0, 0, 1)) begin bad++; $display("FAIL resume got %h want %h", now_t, tm(0, 0, 1)); end
   endtask

   task automatic test_blink;
      step(1'b0, 1'b1, 1'b0);
      cmp++; if (blank !== 2'b00) begin bad++; $display("FAIL blank_enter got %b want 00", blank); end
      ticks(1);
      cmp++; if (blank !== 2'b10) begin bad++; $display("FAIL blank_hr_on got %b want 10", blank); end
      ticks(1);
      cmp++; if (blank !== 2'b00) begin bad++; $display("FAIL blank_hr_off got %b want 00", blank); end
      ticks(1);
      step(1'b0, 1'b1, 1'b0);
      cmp++; if ({mode, blank} !== 4'b1000) begin bad++; $display("FAIL blank_to_min got %b want 1000", {mode, blank}); end
      ticks(1);
      cmp++; if (blank !== 2'b01) begin bad++; $display("FAIL blank_min_on got %b want 01", blank); end
      step(1'b1, 1'b0, 1'b1);
      cmp++; if ({blank, now_t} !== {2'b00, tm(0, 1, 0)}) begin bad++; $display("FAIL inc_with_tick got %h want %h", {blank, now_t}, {2'b00, tm(0, 1, 0)}); end
      step(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_collisions;
      set_time(5, 4);
      ticks(5);
      cmp++; if (now_t !== tm(5, 5, 5)) begin bad++; $display("FAIL t050505 got %h want %h", now_t, tm(5, 5, 5)); end
      step(1'b1, 1'b1, 1'b0);
      cmp++; if ({mode, now_t} !== {2'd1, tm(5, 5, 0)}) begin bad++; $display("FAIL mode_tick got %h want %h", {mode, now_t}, {2'd1, tm(5, 5, 0)}); end
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      cmp++; if ({mode, now_t} !== {2'd0, tm(5, 5, 0)}) begin bad++; $display("FAIL mode_inc got %h want %h", {mode, now_t}, {2'd0, tm(5, 5, 0)}); end
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      ticks(1);
      reset = 1'b1;
      step(1'b1, 1'b0, 1'b1);
      reset = 1'b0;
      cmp++; if ({mode, blank, now_t} !== {4'b0000, tm(23, 59, 0)}) begin bad++; $display("FAIL reset_in_set got %h want %h", {mode, blank, now_t}, {4'b0000, tm(23, 59, 0)}); end
   endtask

`ifdef CLOCK_12H_EN
   task automatic test_12h;
      ticks(59);
      cmp++; if ({pm, now_t} !== {1'b1, tm(23, 59, 59)}) begin bad++; $display("FAIL h12_pre got %h want %h", {pm, now_t}, {1'b1, tm(23, 59, 59)}); end
      ticks(1);
      cmp++; if ({pm, now_t} !== {1'b0, tm(0, 0, 0)}) begin bad++; $display("FAIL h12_midnight got %h want %h", {pm, now_t}, {1'b0, tm(0, 0, 0)}); end
      set_time(11, 59);
      ticks(59);
      cmp++; if ({pm, now_t} !== {1'b0, tm(11, 59, 59)}) begin bad++; $display("FAIL h12_am got %h want %h", {pm, now_t}, {1'b0, tm(11, 59, 59)}); end
      ticks(1);
      cmp++; if ({pm, now_t} !== {1'b1, tm(12, 0, 0)}) begin bad++; $display("FAIL h12_noon got %h want %h", {pm, now_t}, {1'b1, tm(12, 0, 0)}); end
   endtask
`endif

   initial begin
      test_reset;
      test_midnight;
      test_carries;
      test_set_sequence;
      test_blink;
      test_collisions;
`ifdef CLOCK_12H_EN
      test_12h;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Time-of-day sequencer for the board clock. It owns the six BCD digit registers (HH:MM:SS) and cascades them like chained decade counters on each 1 Hz tick.
- Runs a set-mode state machine driven by debounced button pulses, so the user can set hours and minutes.
- Sits between the tick/button front end and the 7-segment display multiplexer.

Parameters:
- INIT_HR_T, 0, tens-of-hours digit loaded on reset (0-2).
- INIT_HR_U, 0, units-of-hours digit loaded on reset (0-9; INIT_HR_T*10+INIT_HR_U must be ≤23).
- INIT_MIN_T, 0, tens-of-minutes digit loaded on reset (0-5).
- INIT_MIN_U, 0, units-of-minutes digit loaded on reset (0-9).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle pulse at 1 Hz.
- btn_mode  input  1  one-cycle debounced pulse; advances the state machine.
- btn_inc  input  1  one-cycle debounced pulse; increments the selected field.
- hr_t  output  4  hours tens digit, BCD.
- hr_u  output  4  hours units digit, BCD.
- min_t  output  4  minutes tens digit, BCD.
- min_u  output  4  minutes units digit, BCD.
- sec_t  output  4  seconds tens digit, BCD.
- sec_u  output  4  seconds units digit, BCD.
- mode  output  2  current state: 0=RUN, 1=SET_HR, 2=SET_MIN.
- blank  output  2  {hours_blank, minutes_blank}; display-blink mask.
- day_pulse  output  1  one-cycle pulse on midnight rollover.

Behaviour:
- All outputs are registered. On reset:
  - digits load the INIT_* values; seconds are 00.
  - mode=RUN, blink=0, blank=00, day_pulse=0.
- Reset has priority over every other input in every state. Reset mid-set abandons the edit.
- State RUN:
  - On tick, sec_u increments. Each digit wraps to 0 and carries to the next digit, all updated on the same edge (latency 1 cycle from tick).
  - Wrap points: sec_u and min_u wrap 9->0; sec_t and min_t wrap 5->0.
  - Hours wrap 23->00; hr_u wraps 9->0 when hr_t<2.
  - 23:59:59 + tick -> 00:00:00, with day_pulse=1 in that same cycle only.
  - btn_inc is ignored.
  - btn_mode -> SET_HR.
- Entering SET_HR: sec_t=sec_u=0, blink=0.
- State SET_HR:
  - tick does not count; it toggles blink.
  - btn_inc: hours +1, 23->00. No carry into or out of minutes; day_pulse stays 0.
  - btn_mode -> SET_MIN, blink cleared to 0.
- State SET_MIN:
  - tick toggles blink.
  - btn_inc: minutes +1, 59->00, no carry to hours.
  - btn_mode -> RUN. Seconds remain 00; counting resumes on the next tick after the transition cycle.
- blank = {(mode==SET_HR)&&blink, (mode==SET_MIN)&&blink}. It is registered with the state.
- Simultaneous events:
  - btn_mode with tick in RUN: mode wins, tick is dropped, seconds cleared.
  - btn_mode with btn_inc in a SET state: mode wins, inc is ignored.
  - btn_inc with tick in a SET state: both act (increment and blink toggle).
- mode value 3 is unreachable; if it is decoded, go to RUN.
- Digit registers never hold non-BCD or out-of-range values.

Optional Feature:
- Macro CLOCK_12H_EN.
- When defined:
  - Adds output port pm (1 bit).
  - hr_t/hr_u present the hour in 12-hour form: internal 00 -> 12, 13..23 -> 01..11, 12 -> 12.
  - pm=1 for internal hours 12-23.
  - The internal 24-hour count, all wrap rules and day_pulse are unchanged; conversion is registered with the digits.
- When undefined: no pm port; hours are presented 00-23 as stored.

Test Plan:
- Reset with INIT 23:59, then apply 59 ticks -> 23:59:59. One more tick -> 00:00:00 with day_pulse high for exactly 1 cycle.
- From 09:59:59, one tick -> 10:00:00. From 19:59:59, one tick -> 20:00:00.
- Set sequence:
  - At 14:37:25 pulse btn_mode -> mode=1, seconds=00.
  - btn_inc ×10 -> hours 00 (wrapped past 23), minutes still 37, day_pulse=0.
  - btn_mode -> mode=2; btn_inc ×23 -> minutes 00, hours unchanged.
  - btn_mode -> RUN; next tick -> 00:00:01.
- Ticks in SET_HR toggle blank[1] 0->1->0, blank[0]=0. After btn_mode, blank=00 until the next tick, then blank[0]=1.
- Collisions:
  - btn_mode and tick in the same cycle at 05:05:05 -> mode=1, time 05:05:00.
  - btn_mode and btn_inc together in SET_MIN -> RUN, minutes unchanged.
  - Reset asserted in SET_MIN -> INIT time, mode=0.
- With CLOCK_12H_EN, walk hours 11:59:59 -> 12:00:00 with pm=1. From 23:59:59 -> displays 12:00:00 with pm=0.
